// File: rtl/or1k_pcu_events.sv
// or1k_pcu_events
//   Turns pipeline, cache and MMU status into single-cycle event strobes for
//   the performance counter unit. Every strobe is registered, so it appears
//   one cycle after the condition was sampled.
//
// Parameters
//   FEATURE_DATACACHE        "ENABLED" | "NONE"  ("NONE" ties dcache_miss to 0)
//   FEATURE_INSTRUCTIONCACHE "ENABLED" | "NONE"  ("NONE" ties icache_miss to 0)
//
// Configuration macro
//   OR1K_PCU_STALL_EPISODE_EN  when defined, each stall strobe fires once on
//                              the rising edge of its stall level (one count
//                              per episode). When undefined, it fires on
//                              every stalled cycle.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   du_stall_i                     debug freeze: strobes 0, all history held
//   padv_fetch_i, fetch_valid_i    instruction fetch event
//   padv_execute_i                 execute advance (qualifies load/store)
//   execute_op_load_i/_store_i     load / store in execute
//   pipeline_flush_i               suppresses load/store/ifetch events
//   dc_refill_i, dc_refill_done_i  dcache refill level / completion pulse
//   ic_refill_i, ic_refill_done_i  icache refill level / completion pulse
//   fetch_stall_i, lsu_stall_i,
//   datadep_stall_i                stall levels
//   branch_mispredict_i,
//   dtlb_miss_i, itlb_miss_i       single-cycle pulses, registered as-is
//   pcu_event_*_o                  registered event strobes
module or1k_pcu_events #(
  parameter FEATURE_DATACACHE        = "ENABLED",
  parameter FEATURE_INSTRUCTIONCACHE = "ENABLED"
) (
  input  logic clk,
  input  logic rst,
  input  logic du_stall_i,
  input  logic padv_fetch_i,
  input  logic fetch_valid_i,
  input  logic padv_execute_i,
  input  logic execute_op_load_i,
  input  logic execute_op_store_i,
  input  logic pipeline_flush_i,
  input  logic dc_refill_i,
  input  logic dc_refill_done_i,
  input  logic ic_refill_i,
  input  logic ic_refill_done_i,
  input  logic fetch_stall_i,
  input  logic lsu_stall_i,
  input  logic datadep_stall_i,
  input  logic branch_mispredict_i,
  input  logic dtlb_miss_i,
  input  logic itlb_miss_i,
  output logic pcu_event_load_o,
  output logic pcu_event_store_o,
  output logic pcu_event_ifetch_o,
  output logic pcu_event_dcache_miss_o,
  output logic pcu_event_icache_miss_o,
  output logic pcu_event_ifetch_stall_o,
  output logic pcu_event_lsu_stall_o,
  output logic pcu_event_brn_stall_o,
  output logic pcu_event_dtlb_miss_o,
  output logic pcu_event_itlb_miss_o,
  output logic pcu_event_datadep_stall_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } refill_state_t;

  // Stall levels bundled as {ifetch, lsu, datadep}.
  logic [2:0] stall_now;
  assign stall_now = {fetch_stall_i, lsu_stall_i, datadep_stall_i};

`ifdef OR1K_PCU_STALL_EPISODE_EN
  // Stall level seen in the last non-frozen cycle, for rising-edge detection.
  logic [2:0] stall_prev;
`endif

  // Pipeline, MMU and stall strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcu_event_load_o          <= 1'b0;
      pcu_event_store_o         <= 1'b0;
      pcu_event_ifetch_o        <= 1'b0;
      pcu_event_brn_stall_o     <= 1'b0;
      pcu_event_dtlb_miss_o     <= 1'b0;
      pcu_event_itlb_miss_o     <= 1'b0;
      pcu_event_ifetch_stall_o  <= 1'b0;
      pcu_event_lsu_stall_o     <= 1'b0;
      pcu_event_datadep_stall_o <= 1'b0;
`ifdef OR1K_PCU_STALL_EPISODE_EN
      stall_prev                <= '0;
`endif
    end else if (du_stall_i) begin
      // Frozen: silence every strobe, keep edge history untouched.
      pcu_event_load_o          <= 1'b0;
      pcu_event_store_o         <= 1'b0;
      pcu_event_ifetch_o        <= 1'b0;
      pcu_event_brn_stall_o     <= 1'b0;
      pcu_event_dtlb_miss_o     <= 1'b0;
      pcu_event_itlb_miss_o     <= 1'b0;
      pcu_event_ifetch_stall_o  <= 1'b0;
      pcu_event_lsu_stall_o     <= 1'b0;
      pcu_event_datadep_stall_o <= 1'b0;
    end else begin
      pcu_event_load_o      <= padv_execute_i & execute_op_load_i  & ~pipeline_flush_i;
      pcu_event_store_o     <= padv_execute_i & execute_op_store_i & ~pipeline_flush_i;
      pcu_event_ifetch_o    <= padv_fetch_i   & fetch_valid_i      & ~pipeline_flush_i;
      pcu_event_brn_stall_o <= branch_mispredict_i;
      pcu_event_dtlb_miss_o <= dtlb_miss_i;
      pcu_event_itlb_miss_o <= itlb_miss_i;
`ifdef OR1K_PCU_STALL_EPISODE_EN
      pcu_event_ifetch_stall_o  <= stall_now[2] & ~stall_prev[2];
      pcu_event_lsu_stall_o     <= stall_now[1] & ~stall_prev[1];
      pcu_event_datadep_stall_o <= stall_now[0] & ~stall_prev[0];
      stall_prev                <= stall_now;
`else
      pcu_event_ifetch_stall_o  <= stall_now[2];
      pcu_event_lsu_stall_o     <= stall_now[1];
      pcu_event_datadep_stall_o <= stall_now[0];
`endif
    end
  end

  // Data-cache miss FSM: one strobe when a refill starts. A done pulse in
  // REFILL wins over a still-high refill level, so a back-to-back refill is
  // picked up from IDLE on the following cycle as a new miss.
  generate
    if (FEATURE_DATACACHE != "NONE") begin : g_dc
      refill_state_t dc_state;

      always_ff @(posedge clk) begin
        if (rst) begin
          dc_state                <= IDLE;
          pcu_event_dcache_miss_o <= 1'b0;
        end else if (du_stall_i) begin
          pcu_event_dcache_miss_o <= 1'b0;
        end else begin
          pcu_event_dcache_miss_o <= 1'b0;
          case (dc_state)
            IDLE: begin
              if (dc_refill_i) begin
                dc_state                <= REFILL;
                pcu_event_dcache_miss_o <= 1'b1;
              end
            end
            REFILL: begin
              if (dc_refill_done_i)
                dc_state <= IDLE;
            end
            default: dc_state <= IDLE;
          endcase
        end
      end
    end else begin : g_no_dc
      assign pcu_event_dcache_miss_o = 1'b0;
    end
  endgenerate

  // Instruction-cache miss FSM, same behaviour as the data-cache one.
  generate
    if (FEATURE_INSTRUCTIONCACHE != "NONE") begin : g_ic
      refill_state_t ic_state;

      always_ff @(posedge clk) begin
        if (rst) begin
          ic_state                <= IDLE;
          pcu_event_icache_miss_o <= 1'b0;
        end else if (du_stall_i) begin
          pcu_event_icache_miss_o <= 1'b0;
        end else begin
          pcu_event_icache_miss_o <= 1'b0;
          case (ic_state)
            IDLE: begin
              if (ic_refill_i) begin
                ic_state                <= REFILL;
                pcu_event_icache_miss_o <= 1'b1;
              end
            end
            REFILL: begin
              if (ic_refill_done_i)
                ic_state <= IDLE;
            end
            default: ic_state <= IDLE;
          endcase
        end
      end
    end else begin : g_no_ic
      assign pcu_event_icache_miss_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_or1k_pcu_events.sv
// Directed bench for or1k_pcu_events. Inputs change 1 time unit after each
// rising edge; outputs are sampled 1 time unit after the next rising edge,
// so each step checks the response to the inputs set just before it.
module tb_or1k_pcu_events;

  logic clk = 1'b0;
  logic rst;
  logic du_stall_i, padv_fetch_i, fetch_valid_i, padv_execute_i;
  logic execute_op_load_i, execute_op_store_i, pipeline_flush_i;
  logic dc_refill_i, dc_refill_done_i, ic_refill_i, ic_refill_done_i;
  logic fetch_stall_i, lsu_stall_i, datadep_stall_i;
  logic branch_mispredict_i, dtlb_miss_i, itlb_miss_i;
  logic pcu_event_load_o, pcu_event_store_o, pcu_event_ifetch_o;
  logic pcu_event_dcache_miss_o, pcu_event_icache_miss_o;
  logic pcu_event_ifetch_stall_o, pcu_event_lsu_stall_o, pcu_event_brn_stall_o;
  logic pcu_event_dtlb_miss_o, pcu_event_itlb_miss_o, pcu_event_datadep_stall_o;

  int checks = 0;
  int errors = 0;

  // Output vector bit positions.
  localparam logic [10:0] LD  = 11'b100_0000_0000;
  localparam logic [10:0] ST  = 11'b010_0000_0000;
  localparam logic [10:0] IF  = 11'b001_0000_0000;
  localparam logic [10:0] DM  = 11'b000_1000_0000;
  localparam logic [10:0] IM  = 11'b000_0100_0000;
  localparam logic [10:0] IFS = 11'b000_0010_0000;
  localparam logic [10:0] LS  = 11'b000_0001_0000;
  localparam logic [10:0] BS  = 11'b000_0000_1000;
  localparam logic [10:0] DT  = 11'b000_0000_0100;
  localparam logic [10:0] IT  = 11'b000_0000_0010;
  localparam logic [10:0] DD  = 11'b000_0000_0001;
  localparam logic [10:0] NONE = 11'b0;

  logic [10:0] outs;
  assign outs = {pcu_event_load_o, pcu_event_store_o, pcu_event_ifetch_o,
                 pcu_event_dcache_miss_o, pcu_event_icache_miss_o,
                 pcu_event_ifetch_stall_o, pcu_event_lsu_stall_o,
                 pcu_event_brn_stall_o, pcu_event_dtlb_miss_o,
                 pcu_event_itlb_miss_o, pcu_event_datadep_stall_o};

  always #5 clk = ~clk;

  or1k_pcu_events #(
    .FEATURE_DATACACHE       ("ENABLED"),
    .FEATURE_INSTRUCTIONCACHE("ENABLED")
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .du_stall_i                (du_stall_i),
    .padv_fetch_i              (padv_fetch_i),
    .fetch_valid_i             (fetch_valid_i),
    .padv_execute_i            (padv_execute_i),
    .execute_op_load_i         (execute_op_load_i),
    .execute_op_store_i        (execute_op_store_i),
    .pipeline_flush_i          (pipeline_flush_i),
    .dc_refill_i               (dc_refill_i),
    .dc_refill_done_i          (dc_refill_done_i),
    .ic_refill_i               (ic_refill_i),
    .ic_refill_done_i          (ic_refill_done_i),
    .fetch_stall_i             (fetch_stall_i),
    .lsu_stall_i               (lsu_stall_i),
    .datadep_stall_i           (datadep_stall_i),
    .branch_mispredict_i       (branch_mispredict_i),
    .dtlb_miss_i               (dtlb_miss_i),
    .itlb_miss_i               (itlb_miss_i),
    .pcu_event_load_o          (pcu_event_load_o),
    .pcu_event_store_o         (pcu_event_store_o),
    .pcu_event_ifetch_o        (pcu_event_ifetch_o),
    .pcu_event_dcache_miss_o   (pcu_event_dcache_miss_o),
    .pcu_event_icache_miss_o   (pcu_event_icache_miss_o),
    .pcu_event_ifetch_stall_o  (pcu_event_ifetch_stall_o),
    .pcu_event_lsu_stall_o     (pcu_event_lsu_stall_o),
    .pcu_event_brn_stall_o     (pcu_event_brn_stall_o),
    .pcu_event_dtlb_miss_o     (pcu_event_dtlb_miss_o),
    .pcu_event_itlb_miss_o     (pcu_event_itlb_miss_o),
    .pcu_event_datadep_stall_o (pcu_event_datadep_stall_o)
  );

  task automatic clear_inputs();
    du_stall_i = 0; padv_fetch_i = 0; fetch_valid_i = 0; padv_execute_i = 0;
    execute_op_load_i = 0; execute_op_store_i = 0; pipeline_flush_i = 0;
    dc_refill_i = 0; dc_refill_done_i = 0; ic_refill_i = 0; ic_refill_done_i = 0;
    fetch_stall_i = 0; lsu_stall_i = 0; datadep_stall_i = 0;
    branch_mispredict_i = 0; dtlb_miss_i = 0; itlb_miss_i = 0;
  endtask

  // Advance one clock and compare the whole output vector.
  task automatic step(input string tag, input logic [10:0] exp);
    @(posedge clk);
    #1;
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, outs, exp);
    end
  endtask

  int dm_count;
  int ls_count;
  int exp_ls;

  initial begin
    clear_inputs();
    rst = 1;
    // Reset must override an active load.
    padv_execute_i = 1; execute_op_load_i = 1; lsu_stall_i = 1;
    step("reset_clears", NONE);
    step("reset_hold", NONE);
    clear_inputs();
    rst = 0;
    step("idle_after_reset", NONE);

    // Three advancing loads, then the same loads under flush.
    padv_execute_i = 1; execute_op_load_i = 1;
    step("load_1", LD);
    step("load_2", LD);
    step("load_3", LD);
    pipeline_flush_i = 1;
    step("load_flush_1", NONE);
    step("load_flush_2", NONE);
    step("load_flush_3", NONE);
    clear_inputs();
    execute_op_load_i = 1;
    step("load_no_padv", NONE);
    clear_inputs();
    padv_execute_i = 1; execute_op_store_i = 1;
    step("store", ST);
    clear_inputs();
    padv_fetch_i = 1; fetch_valid_i = 1;
    step("ifetch", IF);
    padv_fetch_i = 0;
    step("ifetch_not_adv", NONE);
    padv_fetch_i = 1; pipeline_flush_i = 1;
    step("ifetch_flush", NONE);
    clear_inputs();

    // Simultaneous events are all reported together.
    padv_execute_i = 1; execute_op_load_i = 1; dtlb_miss_i = 1; itlb_miss_i = 1;
    step("multi_event", LD | DT | IT);
    clear_inputs();
    branch_mispredict_i = 1;
    step("brn_pulse", BS);
    clear_inputs();
    step("brn_clear", NONE);

    // done in IDLE is ignored.
    dc_refill_done_i = 1;
    step("dc_done_idle", NONE);
    clear_inputs();

    // Refill for 10 cycles with done on cycle 10 and refill still high on
    // cycle 11: misses counted on cycle 1 and cycle 11.
    dm_count = 0;
    for (int i = 1; i <= 11; i++) begin
      dc_refill_i = 1;
      dc_refill_done_i = (i == 10);
      step($sformatf("dc_refill_c%0d", i), (i == 1 || i == 11) ? DM : NONE);
      if (pcu_event_dcache_miss_o === 1'b1) dm_count++;
    end
    clear_inputs();
    dc_refill_done_i = 1;
    step("dc_done_close", NONE);
    clear_inputs();
    checks++;
    assert (dm_count === 2) else begin
      errors++;
      $error("FAIL dc_miss_count observed %0d expected 2", dm_count);
    end

    // LSU stall held for 5 cycles.
`ifdef OR1K_PCU_STALL_EPISODE_EN
    exp_ls = 1;
`else
    exp_ls = 5;
`endif
    ls_count = 0;
    for (int i = 1; i <= 5; i++) begin
      lsu_stall_i = 1;
      step($sformatf("lsu_stall_c%0d", i), (i <= exp_ls) ? LS : NONE);
      if (pcu_event_lsu_stall_o === 1'b1) ls_count++;
    end
    clear_inputs();
    step("lsu_stall_end", NONE);
    checks++;
    assert (ls_count === exp_ls) else begin
      errors++;
      $error("FAIL lsu_stall_count observed %0d expected %0d", ls_count, exp_ls);
    end
    fetch_stall_i = 1; datadep_stall_i = 1;
    step("fetch_dd_stall", IFS | DD);
    clear_inputs();

    // Debug freeze during an icache refill: the done inside the window is lost.
    ic_refill_i = 1;
    step("ic_refill_start", IM);
    du_stall_i = 1; padv_execute_i = 1; execute_op_load_i = 1; dtlb_miss_i = 1;
    lsu_stall_i = 1;
    for (int i = 1; i <= 4; i++) begin
      ic_refill_done_i = (i == 2);
      step($sformatf("du_freeze_c%0d", i), NONE);
    end
    clear_inputs();
    ic_refill_i = 1;
    step("ic_still_refill", NONE);
    ic_refill_i = 0; ic_refill_done_i = 1;
    step("ic_done_after_freeze", NONE);
    clear_inputs();
    ic_refill_i = 1;
    step("ic_new_miss", IM);

    // Reset mid-refill with refill held high: one miss after release.
    rst = 1; padv_fetch_i = 1; fetch_valid_i = 1;
    step("rst_mid_refill_1", NONE);
    step("rst_mid_refill_2", NONE);
    rst = 0; padv_fetch_i = 0; fetch_valid_i = 0;
    step("ic_miss_after_rst", IM);
    step("ic_hold_after_rst", NONE);
    clear_inputs();
    step("final_idle", NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
